// File: rtl/elc3_char_buffer_pkg.sv
// rtl/elc3_char_buffer_pkg.sv - shared constants, fill FSM states and row rotation for the char buffer
package elc3_char_buffer_pkg;

    localparam logic [1:0] CSR_CTRL = 2'd0;
    localparam logic [1:0] CSR_FILL = 2'd1;
    localparam logic [1:0] CSR_BASE = 2'd2;
    localparam logic [1:0] CSR_RSVD = 2'd3;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_SCROLL = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SCROLL = 2'd2
    } fill_state_t;

    // Logical row to physical row: add the rotating base, wrap once at rows.
    function automatic int rotate_row(input int row, input int base, input int rows);
        int sum;
        sum = row + base;
        return (sum >= rows) ? sum - rows : sum;
    endfunction

endpackage

// File: rtl/elc3_char_ram_dp.sv
// rtl/elc3_char_ram_dp.sv - simple dual-port character RAM, port A read/write, port B read-only
// Ports: clk; a_en/a_we/a_addr/a_wdata/a_rdata (CPU or fill engine);
//        b_en/b_addr/b_rdata (video). Both reads registered, old data on read-during-write.
module elc3_char_ram_dp #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 3840,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // RAM power-up image; contents are never touched by reset.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (a_en) begin
            if (a_we) begin
                mem[a_addr] <= a_wdata;
            end
            a_rdata <= mem[a_addr];
        end
        if (b_en) begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/elc3_char_buffer_dp.sv
// rtl/elc3_char_buffer_dp.sv - dual-ported text-mode char buffer with row scrolling and fill engine
// Ports: clk, reset_n (async active-low);
//        s1_* Avalon-MM cell slave (logical {row,col}, read latency 1, waitrequest while filling);
//        s2_* CSR slave (CTRL/FILL/BASE, combinational read);
//        vid_rd/vid_row/vid_col -> vid_char/vid_valid one cycle later, never stalled.
module elc3_char_buffer_dp
    import elc3_char_buffer_pkg::*;
#(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int DATA_W    = 8,
    parameter int COL_W     = $clog2(COLS),
    parameter int ROW_W     = $clog2(ROWS),
    parameter     INIT_FILE = "elc3_char_buffer_dp.hex"
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ROW_W+COL_W-1:0] s1_address,
    input  logic                   s1_chipselect,
    input  logic                   s1_read,
    input  logic                   s1_write,
    input  logic [DATA_W-1:0]      s1_writedata,
    output logic [DATA_W-1:0]      s1_readdata,
    output logic                   s1_waitrequest,
    input  logic [1:0]             s2_address,
    input  logic                   s2_chipselect,
    input  logic                   s2_write,
    input  logic [DATA_W-1:0]      s2_writedata,
    output logic [DATA_W-1:0]      s2_readdata,
    input  logic                   vid_rd,
    input  logic [ROW_W-1:0]       vid_row,
    input  logic [COL_W-1:0]       vid_col,
    output logic [DATA_W-1:0]      vid_char,
    output logic                   vid_valid
);

    localparam int ADDR_W = ROW_W + COL_W;
    localparam int DEPTH  = ROWS << COL_W;

    fill_state_t       state_q, state_d;
    logic              busy;
    logic [ROW_W-1:0]  row_base;
    logic [ROW_W-1:0]  fill_row;
    logic [COL_W-1:0]  fill_col;
    logic [DATA_W-1:0] fill_char;
    logic              last_col, last_row;
    logic              csr_wr;

    logic [ROW_W-1:0]  s1_row, s1_phys, vid_phys;
    logic [COL_W-1:0]  s1_col;
    logic              s1_in_range, vid_in_range;
    logic              s1_req, s1_acc, cpu_we;
    logic              rd_q, rd_ok_q, vid_ok_q;

    logic              a_en, a_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, a_rdata, b_rdata;

    assign busy     = (state_q != ST_IDLE);
    assign last_col = (fill_col == COL_W'(COLS - 1));
    assign last_row = (fill_row == ROW_W'(ROWS - 1));
    assign csr_wr   = s2_chipselect & s2_write & ~busy;

    // CPU address decode and logical-to-physical row mapping
    assign s1_row      = s1_address[ADDR_W-1:COL_W];
    assign s1_col      = s1_address[COL_W-1:0];
    assign s1_in_range = ({1'b0, s1_row} < (ROW_W+1)'(ROWS)) && ({1'b0, s1_col} < (COL_W+1)'(COLS));
    assign s1_phys     = ROW_W'(rotate_row(int'(s1_row), int'(row_base), ROWS));
    assign s1_req      = s1_chipselect & (s1_read | s1_write);
    assign s1_acc      = s1_req & ~busy;
    assign cpu_we      = s1_acc & s1_write & s1_in_range;
    assign s1_waitrequest = s1_req & busy;

    assign vid_in_range = ({1'b0, vid_row} < (ROW_W+1)'(ROWS)) && ({1'b0, vid_col} < (COL_W+1)'(COLS));
    assign vid_phys     = ROW_W'(rotate_row(int'(vid_row), int'(row_base), ROWS));

    // Port A belongs to the fill engine while busy; the CPU is held off by waitrequest then.
    // Out-of-range addresses are steered to 0 so the RAM is never indexed past its depth.
    assign a_en    = busy | s1_acc;
    assign a_we    = busy | cpu_we;
    assign a_addr  = busy ? {fill_row, fill_col} : (s1_in_range ? {s1_phys, s1_col} : '0);
    assign a_wdata = busy ? fill_char : s1_writedata;
    assign b_addr  = vid_in_range ? {vid_phys, vid_col} : '0;

    elc3_char_ram_dp #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .a_en    (a_en),
        .a_we    (a_we),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_rdata (a_rdata),
        .b_en    (vid_rd),
        .b_addr  (b_addr),
        .b_rdata (b_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (csr_wr && s2_address == CSR_CTRL) begin
                    if (s2_writedata[CTRL_CLEAR]) begin
                        state_d = ST_CLEAR;
                    end else if (s2_writedata[CTRL_SCROLL]) begin
                        state_d = ST_SCROLL;
                    end
                end
            end
            ST_CLEAR:  if (last_col && last_row) state_d = ST_IDLE;
            ST_SCROLL: if (last_col) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_base  <= '0;
            fill_char <= '0;
            fill_row  <= '0;
            fill_col  <= '0;
        end else if (!busy) begin
            if (state_d == ST_CLEAR) begin
                fill_row <= '0;
                fill_col <= '0;
            end else if (state_d == ST_SCROLL) begin
                // The row that scrolls off the top becomes the new bottom row and is blanked.
                fill_row <= row_base;
                fill_col <= '0;
                row_base <= (row_base == ROW_W'(ROWS - 1)) ? '0 : row_base + 1'b1;
            end else if (csr_wr) begin
                if (s2_address == CSR_FILL) begin
                    fill_char <= s2_writedata;
                end
                if (s2_address == CSR_BASE && s2_writedata < DATA_W'(ROWS)) begin
                    row_base <= s2_writedata[ROW_W-1:0];
                end
            end
        end else begin
            // Padding columns >= COLS are skipped by wrapping at COLS-1.
            fill_col <= last_col ? '0 : fill_col + 1'b1;
            if (last_col) begin
                fill_row <= fill_row + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q      <= 1'b0;
            rd_ok_q   <= 1'b0;
            vid_valid <= 1'b0;
            vid_ok_q  <= 1'b0;
        end else begin
            rd_q      <= s1_acc & s1_read;
            rd_ok_q   <= s1_in_range;
            vid_valid <= vid_rd;
            vid_ok_q  <= vid_in_range;
        end
    end

    assign s1_readdata = (rd_q && rd_ok_q) ? a_rdata : '0;
    assign vid_char    = (vid_valid && vid_ok_q) ? b_rdata : '0;

    always_comb begin
        s2_readdata = '0;
        if (s2_chipselect) begin
            case (s2_address)
                CSR_CTRL: s2_readdata = DATA_W'(busy);
                CSR_FILL: s2_readdata = fill_char;
                CSR_BASE: s2_readdata = DATA_W'(row_base);
                default:  s2_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_elc3_char_buffer_dp.sv
// tb/tb_elc3_char_buffer_dp.sv - directed vector bench for elc3_char_buffer_dp
module tb_elc3_char_buffer_dp;
    import elc3_char_buffer_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [11:0] s1_address;
    logic        s1_chipselect, s1_read, s1_write;
    logic [7:0]  s1_writedata, s1_readdata;
    logic        s1_waitrequest;
    logic [1:0]  s2_address;
    logic        s2_chipselect, s2_write;
    logic [7:0]  s2_writedata, s2_readdata;
    logic        vid_rd;
    logic [4:0]  vid_row;
    logic [6:0]  vid_col;
    logic [7:0]  vid_char;
    logic        vid_valid;

    int checks   = 0;
    int failures = 0;

    elc3_char_buffer_dp #(.INIT_FILE("")) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s1_address     (s1_address),
        .s1_chipselect  (s1_chipselect),
        .s1_read        (s1_read),
        .s1_write       (s1_write),
        .s1_writedata   (s1_writedata),
        .s1_readdata    (s1_readdata),
        .s1_waitrequest (s1_waitrequest),
        .s2_address     (s2_address),
        .s2_chipselect  (s2_chipselect),
        .s2_write       (s2_write),
        .s2_writedata   (s2_writedata),
        .s2_readdata    (s2_readdata),
        .vid_rd         (vid_rd),
        .vid_row        (vid_row),
        .vid_col        (vid_col),
        .vid_char       (vid_char),
        .vid_valid      (vid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All tasks start and end at posedge+#1 (csr_rd ends a little later in the same cycle).
    task automatic s1_xfer(input logic wr, input int r, input int c, input logic [7:0] d,
                           output logic [7:0] q, output int stalls);
        s1_address    = {5'(r), 7'(c)};
        s1_chipselect = 1'b1;
        s1_write      = wr;
        s1_read       = ~wr;
        s1_writedata  = d;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!s1_waitrequest) break;
            stalls++;
            if (stalls > 5000) begin
                check("s1_stall_bound", 32'(stalls), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        q = s1_readdata;
        s1_chipselect = 1'b0;
        s1_read       = 1'b0;
        s1_write      = 1'b0;
    endtask

    task automatic s1_wr(input int r, input int c, input logic [7:0] d);
        logic [7:0] q;
        int st;
        s1_xfer(1'b1, r, c, d, q, st);
    endtask

    task automatic s1_rd(input int r, input int c, output logic [7:0] q);
        int st;
        s1_xfer(1'b0, r, c, 8'h00, q, st);
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [7:0] d);
        s2_address    = a;
        s2_writedata  = d;
        s2_chipselect = 1'b1;
        s2_write      = 1'b1;
        @(posedge clk);
        #1;
        s2_chipselect = 1'b0;
        s2_write      = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [7:0] q);
        s2_address    = a;
        s2_chipselect = 1'b1;
        s2_write      = 1'b0;
        #2;
        q = s2_readdata;
        s2_chipselect = 1'b0;
    endtask

    task automatic vid_read(input int r, input int c, output logic [7:0] q, output logic v);
        vid_rd  = 1'b1;
        vid_row = 5'(r);
        vid_col = 7'(c);
        @(posedge clk);
        #1;
        q = vid_char;
        v = vid_valid;
        vid_rd = 1'b0;
    endtask

    // Start a fill via CTRL and hold an s1 read on a probe cell; waitrequest cycles = busy cycles.
    task automatic fill_run(input logic [7:0] ctrl, input int r, input int c, input logic do_writes,
                            output int stalls, output logic [7:0] q);
        csr_wr(CSR_CTRL, ctrl);
        s1_address    = {5'(r), 7'(c)};
        s1_chipselect = 1'b1;
        s1_read       = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!s1_waitrequest) break;
            stalls++;
            if (do_writes) begin
                if (stalls == 10) begin
                    s2_address = CSR_FILL; s2_writedata = 8'h55; s2_chipselect = 1'b1; s2_write = 1'b1;
                end else if (stalls == 11) begin
                    s2_address = CSR_BASE; s2_writedata = 8'h04;
                end else if (stalls == 12) begin
                    s2_chipselect = 1'b0; s2_write = 1'b0;
                end
            end
            if (stalls > 5000) begin
                check("fill_bound", 32'(stalls), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        q = s1_readdata;
        s1_chipselect = 1'b0;
        s1_read       = 1'b0;
    endtask

    typedef struct {
        int         row;
        int         col;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0] q;
        logic       v;
        int         st;
        int         errs;

        tbl[0] = '{5,  10,  8'h41, 8'h41};
        tbl[1] = '{0,  0,   8'h11, 8'h11};
        tbl[2] = '{29, 79,  8'h7E, 8'h7E};
        tbl[3] = '{12, 40,  8'hC3, 8'hC3};
        tbl[4] = '{0,  80,  8'h99, 8'h00};
        tbl[5] = '{30, 0,   8'h55, 8'h00};

        reset_n = 1'b0;
        s1_address = '0; s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0; s1_writedata = '0;
        s2_address = '0; s2_chipselect = 1'b0; s2_write = 1'b0; s2_writedata = '0;
        vid_rd = 1'b0; vid_row = '0; vid_col = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", 32'(s1_readdata), 32'h0);
        check("rst_waitreq", 32'(s1_waitrequest), 32'h0);
        check("rst_vid_valid", 32'(vid_valid), 32'h0);
        check("rst_vid_char", 32'(vid_char), 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        csr_rd(CSR_BASE, q);
        check("rst_base", 32'(q), 32'h0);
        csr_rd(CSR_CTRL, q);
        check("rst_busy", 32'(q), 32'h0);
        s1_rd(0, 0, q);
        check("rst_init_word0", 32'(q), 32'h0);

        // Table: write, read back through s1, then through the video port
        for (int i = 0; i < 6; i++) begin
            s1_wr(tbl[i].row, tbl[i].col, tbl[i].data);
            s1_rd(tbl[i].row, tbl[i].col, q);
            check($sformatf("s1_rd[%0d]", i), 32'(q), 32'(tbl[i].exp));
            vid_read(tbl[i].row, tbl[i].col, q, v);
            check($sformatf("vid_valid[%0d]", i), 32'(v), 32'h1);
            check($sformatf("vid_char[%0d]", i), 32'(q), 32'(tbl[i].exp));
        end

        // Full clear with a stalled read on {5,10}
        csr_wr(CSR_FILL, 8'h20);
        fill_run(8'h01, 5, 10, 1'b0, st, q);
        check("clear_busy_cycles", 32'(st), 32'd2400);
        check("clear_stalled_read", 32'(q), 32'h20);
        errs = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++) begin
                s1_rd(r, c, q);
                if (q !== 8'h20) errs++;
            end
        check("clear_all_cells", 32'(errs), 32'h0);
        s1_rd(0, 80, q);
        check("clear_col80", 32'(q), 32'h0);

        // Row rotation mapping
        csr_wr(CSR_BASE, 8'd5);
        s1_wr(0, 0, 8'hA5);
        s1_wr(25, 3, 8'h5A);
        vid_read(25, 3, q, v);
        check("map_vid_wrap", 32'(q), 32'h5A);
        csr_wr(CSR_BASE, 8'd0);
        csr_wr(CSR_BASE, 8'd30);
        csr_rd(CSR_BASE, q);
        check("base_oob_ignored", 32'(q), 32'h0);
        s1_rd(5, 0, q);
        check("map_phys5", 32'(q), 32'hA5);
        s1_rd(0, 3, q);
        check("map_phys0_wrap", 32'(q), 32'h5A);

        // Scroll from the last base wraps to 0 and blanks physical row 29
        csr_wr(CSR_FILL, 8'h33);
        csr_wr(CSR_BASE, 8'd29);
        csr_rd(CSR_BASE, q);
        check("base_29", 32'(q), 32'd29);
        fill_run(8'h02, 0, 0, 1'b0, st, q);
        check("scroll_busy_cycles", 32'(st), 32'd80);
        check("scroll_probe_row0", 32'(q), 32'h20);
        csr_rd(CSR_BASE, q);
        check("scroll_base_wrap", 32'(q), 32'h0);
        s1_rd(29, 5, q);
        check("scroll_row29", 32'(q), 32'h33);
        s1_rd(28, 5, q);
        check("scroll_row28", 32'(q), 32'h20);

        // CLEAR|SCROLL: clear only; CSR writes while busy ignored
        csr_wr(CSR_FILL, 8'h44);
        fill_run(8'h03, 3, 3, 1'b1, st, q);
        check("both_busy_cycles", 32'(st), 32'd2400);
        check("both_probe", 32'(q), 32'h44);
        csr_rd(CSR_BASE, q);
        check("both_base_kept", 32'(q), 32'h0);
        csr_rd(CSR_FILL, q);
        check("both_fill_kept", 32'(q), 32'h44);
        s1_rd(29, 79, q);
        check("both_last_cell", 32'(q), 32'h44);

        // Reset during clear after 100 fill writes
        csr_wr(CSR_FILL, 8'h66);
        csr_wr(CSR_BASE, 8'd7);
        csr_wr(CSR_CTRL, 8'h01);
        repeat (100) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        csr_rd(CSR_CTRL, q);
        check("rstfill_busy", 32'(q), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        csr_rd(CSR_BASE, q);
        check("rstfill_base", 32'(q), 32'h0);
        csr_rd(CSR_FILL, q);
        check("rstfill_fill", 32'(q), 32'h0);
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            s1_rd(k / 80, k % 80, q);
            if (q !== 8'h66) errs++;
        end
        check("rstfill_cells_0_99", 32'(errs), 32'h0);
        s1_rd(1, 20, q);
        check("rstfill_cell_100", 32'(q), 32'h44);
        s1_rd(29, 79, q);
        check("rstfill_last_cell", 32'(q), 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
